// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: local command port and APB bus signals of the bridge
interface apb_master_bridge_if #(
  parameter int NUM_SLV = 4
);
  logic                   req;
  logic                   write;
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic                   ready;
  logic                   done;
  logic                   err;
  logic [31:0]            rdata;
  logic [31:0]            PADDR;
  logic [31:0]            PWDATA;
  logic                   PWRITE;
  logic [NUM_SLV-1:0]     PSEL;
  logic                   PENABLE;
  logic [32*NUM_SLV-1:0]  PRDATA;
  logic [NUM_SLV-1:0]     PREADY;
  modport master (
    input  req, write, addr, wdata, PRDATA, PREADY,
    output ready, done, err, rdata, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
  modport slave (
    output req, write, addr, wdata, PRDATA, PREADY,
    input  ready, done, err, rdata, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-word command to APB SETUP/ACCESS initiator with decode and timeout abort
module apb_master_bridge #(
  parameter int NUM_SLV     = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 4_000_000
) (
  input  logic PCLK,
  input  logic PRESET,
  apb_master_bridge_if.master bus
);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t        state;
  logic [3:0]    idx;
  logic [3:0]    req_idx;
  logic [CW-1:0] cnt;
  logic [15:0]   pready_x;
  logic [31:0]   prd [16];
  assign req_idx  = bus.addr[SEL_LSB+3:SEL_LSB];
  assign pready_x = 16'(bus.PREADY);
  assign bus.ready = state == IDLE;
  for (genvar i = 0; i < 16; i++) begin : g_prd
    if (i < NUM_SLV) begin : g_on
      assign prd[i] = bus.PRDATA[32*i +: 32];
    end else begin : g_off
      assign prd[i] = '0;
    end
  end
  // transfer sequencing with registered bus outputs and completion pulses
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      bus.PSEL    <= '0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PADDR   <= '0;
      bus.PWDATA  <= '0;
      bus.rdata   <= '0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (32'(req_idx) < NUM_SLV) begin
              idx        <= req_idx;
              bus.PADDR  <= bus.addr;
              bus.PWDATA <= bus.wdata;
              bus.PWRITE <= bus.write;
              bus.PSEL   <= NUM_SLV'(1) << req_idx;
              state      <= SETUP;
            end else begin
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          cnt         <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (pready_x[idx]) begin
            if (!bus.PWRITE) bus.rdata <= prd[idx];
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            bus.done    <= 1'b1;
            state       <= IDLE;
          end else if (TIMEOUT_CYC != 0 && cnt == CW'(TIMEOUT_CYC)) begin
            bus.PSEL    <= '0;
            bus.PENABLE <= 1'b0;
            bus.done    <= 1'b1;
            bus.err     <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed table-driven checks of the APB master bridge
module tb_apb_master_bridge;
  logic PCLK = 1'b0;
  logic PRESET;
  int total = 0;
  int passed = 0;
  apb_master_bridge_if #(.NUM_SLV(4)) bus ();
  apb_master_bridge #(.NUM_SLV(4), .SEL_LSB(12), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .bus(bus)
  );
  always #5 PCLK = ~PCLK;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    int          slv;
    int          waits;
    logic [3:0]  stray;
    logic        dec;
    logic [3:0]  psel;
    logic [31:0] rexp;
  } vec_t;
  vec_t tbl [10];
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic txn(input vec_t v);
    logic [3:0]   me;
    logic [127:0] prd;
    me  = v.dec ? 4'b0 : 4'(1 << v.slv);
    prd = {4{32'hDEADBEEF}};
    if (!v.dec) prd[32*v.slv +: 32] = v.rdat;
    bus.PRDATA = prd;
    bus.PREADY = v.stray & ~me;
    bus.write  = v.wr;
    bus.addr   = v.addr;
    bus.wdata  = v.wdata;
    bus.req    = 1'b1;
    step();
    bus.req = 1'b0;
    if (v.dec) begin
      chk("dec_done", 32'(bus.done), 1);
      chk("dec_err", 32'(bus.err), 1);
      chk("dec_psel", 32'(bus.PSEL), 0);
      chk("dec_ready", 32'(bus.ready), 1);
      chk("dec_rdata", bus.rdata, v.rexp);
      step();
      chk("dec_pulse", 32'(bus.done), 0);
      chk("dec_psel2", 32'(bus.PSEL), 0);
    end else begin
      chk("setup_psel", 32'(bus.PSEL), 32'(v.psel));
      chk("setup_penable", 32'(bus.PENABLE), 0);
      chk("setup_paddr", bus.PADDR, v.addr);
      chk("setup_pwrite", 32'(bus.PWRITE), 32'(v.wr));
      if (v.wr) chk("setup_pwdata", bus.PWDATA, v.wdata);
      chk("setup_ready", 32'(bus.ready), 0);
      step();
      chk("access_penable", 32'(bus.PENABLE), 1);
      chk("access_psel", 32'(bus.PSEL), 32'(v.psel));
      for (int i = 0; i < v.waits; i++) begin
        step();
        chk("wait_penable", 32'(bus.PENABLE), 1);
        chk("wait_done", 32'(bus.done), 0);
      end
      bus.PREADY = v.stray | me;
      step();
      chk("end_done", 32'(bus.done), 1);
      chk("end_err", 32'(bus.err), 0);
      chk("end_psel", 32'(bus.PSEL), 0);
      chk("end_penable", 32'(bus.PENABLE), 0);
      chk("end_rdata", bus.rdata, v.rexp);
      chk("end_paddr_held", bus.PADDR, v.addr);
      chk("end_ready", 32'(bus.ready), 1);
      bus.PREADY = 4'b0;
      step();
      chk("end_pulse", 32'(bus.done), 0);
    end
  endtask
  initial begin
    tbl[0] = '{1'b1, 32'h0000_1000, 32'h0000_0001, 32'h0,         1, 0,  4'b0000, 1'b0, 4'b0010, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_2004, 32'h0,         32'h0000_03E8, 2, 3,  4'b0000, 1'b0, 4'b0100, 32'h0000_03E8};
    tbl[2] = '{1'b1, 32'h0000_3010, 32'hCAFE_F00D, 32'h0,         3, 1,  4'b0001, 1'b0, 4'b1000, 32'h0000_03E8};
    tbl[3] = '{1'b1, 32'h0000_5000, 32'h1234_0000, 32'h0,         0, 0,  4'b0000, 1'b1, 4'b0000, 32'h0000_03E8};
    tbl[4] = '{1'b0, 32'h0000_0ABC, 32'h0,         32'h1234_5678, 0, 2,  4'b1110, 1'b0, 4'b0001, 32'h1234_5678};
    tbl[5] = '{1'b0, 32'h0000_F000, 32'h0,         32'h0,         0, 0,  4'b0000, 1'b1, 4'b0000, 32'h1234_5678};
    tbl[6] = '{1'b0, 32'hFFFF_3FFC, 32'h0,         32'h0000_A5A5, 3, 0,  4'b0111, 1'b0, 4'b1000, 32'h0000_A5A5};
    tbl[7] = '{1'b0, 32'h0000_2004, 32'h0,         32'h0000_03E8, 2, 0,  4'b0000, 1'b0, 4'b0100, 32'h0000_03E8};
    tbl[8] = '{1'b0, 32'h0000_2000, 32'h0,         32'h0000_0077, 2, 16, 4'b0000, 1'b0, 4'b0100, 32'h0000_0077};
    tbl[9] = '{1'b0, 32'h0000_1008, 32'h0,         32'h0000_CAFE, 1, 1,  4'b0000, 1'b0, 4'b0010, 32'h0000_CAFE};
    PRESET = 1'b0;
    bus.req = 1'b0;
    bus.write = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.PRDATA = '0;
    bus.PREADY = '0;
    step();
    step();
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_psel", 32'(bus.PSEL), 0);
    chk("rst_penable", 32'(bus.PENABLE), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_pwrite", 32'(bus.PWRITE), 0);
    PRESET = 1'b1;
    step();
    for (int k = 0; k < 8; k++) txn(tbl[k]);
    bus.PRDATA = {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5555_5555};
    bus.PREADY = 4'b0;
    bus.write = 1'b0;
    bus.addr = 32'h0;
    bus.req = 1'b1;
    step();
    bus.req = 1'b0;
    chk("to_setup_psel", 32'(bus.PSEL), 1);
    step();
    chk("to_access_penable", 32'(bus.PENABLE), 1);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("to_wait_penable", 32'(bus.PENABLE), 1);
      chk("to_wait_done", 32'(bus.done), 0);
    end
    step();
    chk("to_psel", 32'(bus.PSEL), 0);
    chk("to_penable", 32'(bus.PENABLE), 0);
    chk("to_done", 32'(bus.done), 1);
    chk("to_err", 32'(bus.err), 1);
    chk("to_rdata", bus.rdata, 32'h0000_03E8);
    chk("to_ready", 32'(bus.ready), 1);
    step();
    chk("to_pulse", 32'(bus.done), 0);
    txn(tbl[8]);
    bus.PREADY = 4'b0001;
    bus.write = 1'b1;
    bus.addr = 32'h0000_3000;
    bus.wdata = 32'h0000_0011;
    bus.req = 1'b1;
    step();
    chk("b2b_setup1_psel", 32'(bus.PSEL), 32'h8);
    step();
    chk("b2b_access1", 32'(bus.PENABLE), 1);
    step();
    chk("b2b_stray_penable", 32'(bus.PENABLE), 1);
    chk("b2b_stray_done", 32'(bus.done), 0);
    bus.PREADY = 4'b1001;
    step();
    chk("b2b_done1", 32'(bus.done), 1);
    chk("b2b_err1", 32'(bus.err), 0);
    chk("b2b_ready1", 32'(bus.ready), 1);
    bus.addr = 32'h0000_3004;
    bus.wdata = 32'h0000_0022;
    step();
    bus.req = 1'b0;
    chk("b2b_setup2_psel", 32'(bus.PSEL), 32'h8);
    chk("b2b_setup2_paddr", bus.PADDR, 32'h0000_3004);
    chk("b2b_setup2_pwdata", bus.PWDATA, 32'h0000_0022);
    chk("b2b_setup2_done", 32'(bus.done), 0);
    step();
    chk("b2b_access2_done", 32'(bus.done), 0);
    step();
    chk("b2b_done2", 32'(bus.done), 1);
    chk("b2b_err2", 32'(bus.err), 0);
    chk("b2b_rdata", bus.rdata, 32'h0000_0077);
    bus.PREADY = 4'b0;
    step();
    bus.write = 1'b0;
    bus.addr = 32'h0000_1000;
    bus.PRDATA = {4{32'h0BAD_0BAD}};
    bus.req = 1'b1;
    step();
    step();
    bus.req = 1'b0;
    chk("rm_access", 32'(bus.PENABLE), 1);
    PRESET = 1'b0;
    step();
    PRESET = 1'b1;
    chk("rm_psel", 32'(bus.PSEL), 0);
    chk("rm_penable", 32'(bus.PENABLE), 0);
    chk("rm_done", 32'(bus.done), 0);
    chk("rm_rdata", bus.rdata, 0);
    chk("rm_ready", 32'(bus.ready), 1);
    txn(tbl[9]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that turns single-word commands from a local requester (CPU core, test sequencer, DMA) into APB SETUP/ACCESS transfers.
- Drives the shared APB bus for up to NUM_SLV peripheral slaves: PADDR, PWDATA, PWRITE, PENABLE and a one-hot PSEL.
- Honours slave wait states and returns read data. Slow peripherals (e.g. the ultrasonic block) may hold PREADY low for milliseconds.
- Aborts with an error flag on decode miss or timeout.

Parameters:
- NUM_SLV, 4, number of slaves; legal range 1..16.
- SEL_LSB, 12, LSB of the 4-bit slave-index field addr[SEL_LSB+3:SEL_LSB].
- TIMEOUT_CYC, 4_000_000, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset; synchronous, active-low.
- req  in  1  command request; sampled only while ready=1.
- write  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  32  write data.
- ready  out  1  bridge idle and able to accept a command.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = decode error or timeout.
- rdata  out  32  read data; holds its value until the next successful read.
- PADDR  out  32  APB address; slaves connect the low bits.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- PRDATA  in  32*NUM_SLV  flattened read data; slave i occupies bits [32*i+31:32*i].
- PREADY  in  NUM_SLV  per-slave ready.

Behaviour:
- Reset (PRESET=0 at a PCLK edge):
  - state = IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, done, err = 0; timeout counter = 0.
  - ready = 1 after reset, because ready is combinational: state==IDLE.
  - Reset mid-transfer takes effect at the same edge: bus released, no done pulse.
- FSM states IDLE, SETUP, ACCESS.
- IDLE:
  - req=1 at edge T captures write/addr/wdata into internal registers.
  - idx = addr[SEL_LSB+3:SEL_LSB].
  - If idx >= NUM_SLV: stay in IDLE; at T+1 done=1, err=1; no PSEL asserted.
  - Otherwise: go to SETUP at T+1.
- SETUP (exactly 1 cycle):
  - PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA = captured values.
  - Go to ACCESS.
- ACCESS:
  - PENABLE=1; PSEL, PADDR, PWRITE, PWDATA held stable.
  - Each cycle, sample only PREADY[idx]; PREADY of unselected slaves is ignored.
  - PREADY[idx]=1 at edge E:
    - Read: rdata <= PRDATA slice idx.
    - Write: rdata unchanged.
    - At E+1: PSEL=0, PENABLE=0, done=1, err=0, state=IDLE.
  - Timeout counter starts at 0 on entry to ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter reaches TIMEOUT_CYC (TIMEOUT_CYC≠0): abort. At the next edge bus is released, done=1, err=1, rdata unchanged, state=IDLE.
  - PREADY[idx]=1 in the same cycle the counter hits the limit counts as success.
- done and err are registered one-cycle pulses; err=0 whenever done=0.
- Back-to-back: a req present in the done cycle (state IDLE) is accepted. Zero-wait-state throughput is one transfer per 3 cycles.
- req while ready=0 is ignored; there is no queue. The requester holds req until it sees ready.
- PADDR, PWDATA and PWRITE keep their last values in IDLE; only PSEL and PENABLE return to 0.
- Counter width is $clog2(TIMEOUT_CYC+1), minimum 1.

Test Plan:
- Zero-wait write:
  - Stimulus: req at T, write=1, addr=0x0000_1000, wdata=0x1, PREADY[1]=1.
  - Required: T+1 PSEL=4'b0010, PENABLE=0, PADDR=0x1000; T+2 PENABLE=1; T+3 PSEL=0, done=1, err=0.
- Wait-state read:
  - Stimulus: read addr=0x0000_2004; slave 2 raises PREADY after 3 low ACCESS cycles with PRDATA slice 2 = 0x0000_03E8.
  - Required: PENABLE high for 4 cycles; done=1, err=0, rdata=0x3E8; other PRDATA slices (set to 0xDEADBEEF) ignored.
- Timeout:
  - Stimulus: TIMEOUT_CYC=16, read slave 0, PREADY held 0.
  - Required: after 16 ACCESS cycles, next edge PSEL=0, PENABLE=0, done=1, err=1; rdata keeps its previous value 0x3E8.
- Decode error:
  - Stimulus: NUM_SLV=4, addr=0x0000_5000.
  - Required: PSEL stays 0 throughout; done=1, err=1 at T+1; ready stays 1.
- Back-to-back with stray ready:
  - Stimulus: two writes to slave 3 with req held high; PREADY[0] held 1 throughout.
  - Required: second command accepted in the first done cycle; ACCESS waits on PREADY[3] only; two done pulses 3 cycles apart when PREADY[3]=1.
- Reset mid-ACCESS:
  - Stimulus: PRESET=0 for 1 cycle during ACCESS of a read.
  - Required: next edge PSEL=0, PENABLE=0, done=0, rdata=0, ready=1; a subsequent command completes normally.
